// File: rtl/video_compositor_pkg.sv
// Shared pixel types, base-layer modes and constants for the video compositor.
package video_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    BASE_CAMERA  = 2'd0,
    BASE_GREY_HL = 2'd1,
    BASE_MASK    = 2'd2,
    BASE_BLACK   = 2'd3
  } base_mode_t;

  localparam int unsigned COMPOSITOR_LATENCY = 2;
  localparam rgb_t        RGB_BLACK          = '0;
  localparam rgb_t        RGB_WHITE          = '1;

endpackage

// File: rtl/video_compositor_blend_avg.sv
// Combinational per-channel 50% average of two RGB pixels (9-bit sum, >>1).
module pixel_blend_avg
  import video_pkg::*;
(
  input  rgb_t a_in,
  input  rgb_t b_in,
  output rgb_t avg_out
);

  logic [8:0] sum_r;
  logic [8:0] sum_g;
  logic [8:0] sum_b;

  always_comb begin
    sum_r     = {1'b0, a_in.r} + {1'b0, b_in.r};
    sum_g     = {1'b0, a_in.g} + {1'b0, b_in.g};
    sum_b     = {1'b0, a_in.b} + {1'b0, b_in.b};
    avg_out.r = sum_r[8:1];
    avg_out.g = sum_g[8:1];
    avg_out.b = sum_b[8:1];
  end

endmodule

// File: rtl/video_compositor.sv
// Two-stage base + keyed-overlay pixel compositor with frame-start shadowed config.
// Optional per-layer 50% blending is built when VIDEO_COMPOSITOR_BLEND_EN is defined.
module video_compositor
  import video_pkg::*;
#(
  parameter int unsigned        NUM_LAYERS    = 4,
  parameter int unsigned        PIXEL_W       = 24,
  parameter logic [PIXEL_W-1:0] HIGHLIGHT_RGB = 24'hFF77AA
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          frame_start_in,
  input  logic [1:0]                    mode_in,
  input  logic [NUM_LAYERS-1:0]         layer_en_in,
  input  logic [NUM_LAYERS-1:0]         blend_en_in,
  input  logic [PIXEL_W-1:0]            camera_pixel_in,
  input  logic [7:0]                    camera_y_in,
  input  logic                          thresholded_pixel_in,
  input  logic [NUM_LAYERS*PIXEL_W-1:0] layer_pixel_in,
  input  logic [NUM_LAYERS-1:0]         layer_key_in,
  input  logic                          active_in,
  input  logic                          hsync_in,
  input  logic                          vsync_in,
  output logic [PIXEL_W-1:0]            pixel_out,
  output logic                          active_out,
  output logic                          hsync_out,
  output logic                          vsync_out
);

  base_mode_t                    shadow_mode;
  logic [NUM_LAYERS-1:0]         shadow_en;
  base_mode_t                    eff_mode;
  logic [NUM_LAYERS-1:0]         eff_en;
  logic [PIXEL_W-1:0]            base_d;

  logic [PIXEL_W-1:0]            base_q;
  logic [NUM_LAYERS*PIXEL_W-1:0] layer_q;
  logic [NUM_LAYERS-1:0]         key_q;
  logic [2:0]                    tim_s1;

  logic [NUM_LAYERS:0][PIXEL_W-1:0] acc_chain;
  logic [PIXEL_W-1:0]            pixel_q;
  logic [2:0]                    tim_s2;

  // The frame-start pixel itself must already see the newly requested config.
  assign eff_mode = frame_start_in ? base_mode_t'(mode_in) : shadow_mode;
  assign eff_en   = frame_start_in ? layer_en_in : shadow_en;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      shadow_mode <= BASE_CAMERA;
      shadow_en   <= '0;
    end else if (frame_start_in) begin
      shadow_mode <= eff_mode;
      shadow_en   <= eff_en;
    end
  end

  always_comb begin
    base_d = '0;
    unique case (eff_mode)
      BASE_CAMERA:  base_d = camera_pixel_in;
      BASE_GREY_HL: base_d = thresholded_pixel_in ? HIGHLIGHT_RGB : {3{camera_y_in}};
      BASE_MASK:    base_d = thresholded_pixel_in ? RGB_WHITE : RGB_BLACK;
      default:      base_d = RGB_BLACK;
    endcase
  end

`ifdef VIDEO_COMPOSITOR_BLEND_EN
  logic [NUM_LAYERS-1:0] shadow_blend;
  logic [NUM_LAYERS-1:0] eff_blend;
  logic [NUM_LAYERS-1:0] blend_q;

  assign eff_blend = frame_start_in ? blend_en_in : shadow_blend;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      shadow_blend <= '0;
      blend_q      <= '0;
    end else begin
      if (frame_start_in) shadow_blend <= eff_blend;
      blend_q <= eff_blend;
    end
  end
`else
  logic unused_blend_en;
  assign unused_blend_en = ^blend_en_in;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      base_q  <= '0;
      layer_q <= '0;
      key_q   <= '0;
      tim_s1  <= '0;
    end else begin
      base_q  <= base_d;
      layer_q <= layer_pixel_in;
      key_q   <= layer_key_in & eff_en;
      tim_s1  <= {active_in, hsync_in, vsync_in};
    end
  end

  // Priority chain from layer 0 upward, so the highest keyed index lands last.
  assign acc_chain[0] = base_q;

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
    logic [PIXEL_W-1:0] layer_px;
    assign layer_px = layer_q[i*PIXEL_W +: PIXEL_W];
`ifdef VIDEO_COMPOSITOR_BLEND_EN
    rgb_t avg_px;
    pixel_blend_avg u_avg (
      .a_in    (layer_px),
      .b_in    (acc_chain[i]),
      .avg_out (avg_px)
    );
    assign acc_chain[i+1] = !key_q[i] ? acc_chain[i] :
                            (blend_q[i] ? avg_px : layer_px);
`else
    assign acc_chain[i+1] = key_q[i] ? layer_px : acc_chain[i];
`endif
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pixel_q <= '0;
      tim_s2  <= '0;
    end else begin
      pixel_q <= tim_s1[2] ? acc_chain[NUM_LAYERS] : '0;
      tim_s2  <= tim_s1;
    end
  end

  assign pixel_out  = pixel_q;
  assign active_out = tim_s2[2];
  assign hsync_out  = tim_s2[1];
  assign vsync_out  = tim_s2[0];

endmodule
